// File: rtl/voice_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : voice_scheduler                                            |
// | Description : Polyphonic voice allocator and sample sequencer. Maps held |
// |               keys onto NUM_VOICES phase accumulators, shares a single   |
// |               synchronous sine LUT between the voices, and writes one    |
// |               mixed sample each time the codec FIFO has space.           |
// | Option      : VOICE_STEAL_EN - when defined, a press with no free voice  |
// |               takes over the oldest active voice (ties go to the lowest  |
// |               index). When undefined, such a press is dropped.           |
// | Ports       : CLOCK_50          - single clock, rising edge              |
// |               reset_n           - asynchronous active-low reset          |
// |               key_level         - per-key level, already synchronised    |
// |               key_incr          - per-key phase increment, PHASE_W each  |
// |               audio_out_allowed - codec FIFO can accept a word           |
// |               lut_addr/lut_data - shared LUT port, data one cycle later  |
// |               sample_out        - left-justified mix, held between writes|
// |               write_audio_out   - one-cycle write strobe                 |
// |               voice_active      - per-voice busy flags                   |
// |               overflow          - sticky, a press found no free voice    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module voice_scheduler #(
  parameter int NUM_KEYS   = 10,
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int LUT_AW     = 10,
  parameter int LUT_W      = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic [NUM_KEYS-1:0]         key_level,
  input  logic [NUM_KEYS*PHASE_W-1:0] key_incr,
  input  logic                        audio_out_allowed,
  output logic [LUT_AW-1:0]           lut_addr,
  input  logic [LUT_W-1:0]            lut_data,
  output logic [31:0]                 sample_out,
  output logic                        write_audio_out,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic                        overflow
);

  localparam int c_KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int c_VIDX_W = $clog2(NUM_VOICES);
  localparam int c_MIX_W  = LUT_W + c_VIDX_W;
  localparam logic [c_KEY_W-1:0]  c_LAST_KEY   = c_KEY_W'(NUM_KEYS - 1);
  localparam logic [c_VIDX_W-1:0] c_LAST_VOICE = c_VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Key scanner and held-key bookkeeping
  logic [c_KEY_W-1:0]   r_scan_idx;
  logic [NUM_KEYS-1:0]  r_key_held;
  logic                 w_scan_level;
  logic                 w_scan_held;
  logic                 w_press;
  logic                 w_release;

  // Voice table
  logic [NUM_VOICES-1:0] r_active;
  logic [c_KEY_W-1:0]    r_key   [NUM_VOICES];
  logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_rel_hit;
  logic                  w_free_found;
  logic [c_VIDX_W-1:0]   w_free_idx;
  logic                  w_alloc_en;
  logic [c_VIDX_W-1:0]   w_alloc_idx;

  // Fetch / mix datapath
  logic [c_VIDX_W-1:0]   r_fetch_idx;
  logic                  r_addr_active;
  logic [c_MIX_W-1:0]    r_mix;
  logic [c_MIX_W-1:0]    w_mix_add;
  logic [c_MIX_W-1:0]    w_mix_next;
  logic [PHASE_W-1:0]    w_fetch_incr;
  logic [31:0]           r_sample;
  logic                  r_overflow;

  // ---------------------------------------------------------------------------
  // Sample sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    write_audio_out = 1'b0;
    lut_addr        = '0;
    case (r_state)
      S_IDLE: begin
        if (audio_out_allowed) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        // The LUT sees the phase before this cycle's increment is applied.
        lut_addr = r_phase[r_fetch_idx][PHASE_W-1 -: LUT_AW];
        if (r_fetch_idx == c_LAST_VOICE) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        write_audio_out = 1'b1;
        w_state_next    = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Key scanner: one key per IDLE cycle, frozen during a sample sequence so
  // the voice table is never touched while phases are being advanced.
  // ---------------------------------------------------------------------------
  assign w_scan_level = key_level[r_scan_idx];
  assign w_scan_held  = r_key_held[r_scan_idx];
  assign w_press      = (r_state == S_IDLE) &&  w_scan_level && !w_scan_held;
  assign w_release    = (r_state == S_IDLE) && !w_scan_level &&  w_scan_held;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_idx <= '0;
      r_key_held <= '0;
    end else if (r_state == S_IDLE) begin
      r_scan_idx <= (r_scan_idx == c_LAST_KEY) ? '0 : r_scan_idx + c_KEY_W'(1);
      if (w_press) begin
        r_key_held[r_scan_idx] <= 1'b1;
      end else if (w_release) begin
        r_key_held[r_scan_idx] <= 1'b0;
      end
    end
  end

  // Lowest-index free voice: scanning downward lets the last hit win.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!r_active[v]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_VIDX_W'(v);
      end
    end
  end

  always_comb begin
    w_rel_hit = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_rel_hit[v] = w_release && r_active[v] && (r_key[v] == r_scan_idx);
    end
  end

`ifdef VOICE_STEAL_EN
  logic [c_VIDX_W-1:0] r_age [NUM_VOICES];
  logic [c_VIDX_W-1:0] w_victim_idx;
  logic [c_VIDX_W-1:0] w_victim_age;

  // Oldest voice; strict compare keeps the lowest index on a tie.
  always_comb begin
    w_victim_idx = '0;
    w_victim_age = r_age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (r_age[v] > w_victim_age) begin
        w_victim_idx = c_VIDX_W'(v);
        w_victim_age = r_age[v];
      end
    end
  end

  always_comb begin
    w_alloc_en  = w_press;
    w_alloc_idx = w_free_found ? w_free_idx : w_victim_idx;
  end

  // Every other active voice ages by one per accepted press, saturating.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_age[v] <= '0;
      end
    end else if (w_alloc_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_alloc_idx == c_VIDX_W'(v)) begin
          r_age[v] <= '0;
        end else if (r_active[v] && (r_age[v] != '1)) begin
          r_age[v] <= r_age[v] + c_VIDX_W'(1);
        end
      end
    end
  end
`else
  always_comb begin
    w_alloc_en  = w_press && w_free_found;
    w_alloc_idx = w_free_idx;
  end
`endif

  // Increment of the key owned by the voice being fetched.
  always_comb begin
    w_fetch_incr = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (r_key[r_fetch_idx] == c_KEY_W'(k)) begin
        w_fetch_incr = key_incr[k*PHASE_W +: PHASE_W];
      end
    end
  end

  // Voice table: allocation/release happen in IDLE, phase advance in FETCH,
  // so the three update sources are mutually exclusive.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_key[v]   <= '0;
        r_phase[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_alloc_en && (w_alloc_idx == c_VIDX_W'(v))) begin
          r_active[v] <= 1'b1;
          r_key[v]    <= r_scan_idx;
          r_phase[v]  <= '0;
        end else if (w_rel_hit[v]) begin
          r_active[v] <= 1'b0;
          r_phase[v]  <= '0;
        end else if ((r_state == S_FETCH) && (r_fetch_idx == c_VIDX_W'(v)) && r_active[v]) begin
          r_phase[v]  <= r_phase[v] + w_fetch_incr;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_press && !w_free_found) begin
      r_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mixer: lut_data lags lut_addr by one cycle, so r_addr_active remembers
  // whether the voice addressed last cycle should contribute.
  // ---------------------------------------------------------------------------
  assign w_mix_add  = r_addr_active ? {{c_VIDX_W{lut_data[LUT_W-1]}}, lut_data} : '0;
  assign w_mix_next = r_mix + w_mix_add;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_idx   <= '0;
      r_addr_active <= 1'b0;
      r_mix         <= '0;
      r_sample      <= '0;
    end else begin
      r_addr_active <= (r_state == S_FETCH) && r_active[r_fetch_idx];
      if (r_state == S_FETCH) begin
        r_fetch_idx <= (r_fetch_idx == c_LAST_VOICE) ? '0 : r_fetch_idx + c_VIDX_W'(1);
      end else begin
        r_fetch_idx <= '0;
      end
      // Clearing throughout IDLE guarantees a zero accumulator on FETCH entry.
      if (r_state == S_IDLE) begin
        r_mix <= '0;
      end else if (r_state == S_FETCH) begin
        r_mix <= w_mix_next;
      end
      if (r_state == S_DRAIN) begin
        r_sample <= 32'(w_mix_next) << (32 - c_MIX_W);
      end
    end
  end

  assign sample_out   = r_sample;
  assign voice_active = r_active;
  assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
module tb_voice_scheduler;

  localparam int NK = 10;
  localparam int NV = 4;
  localparam int PW = 32;
  localparam int AW = 10;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NK-1:0]     key_level;
  logic [NK*PW-1:0]  key_incr;
  logic              allowed;
  logic [AW-1:0]     lut_addr;
  logic [LW-1:0]     lut_data;
  logic [31:0]       sample_out;
  logic              write_audio_out;
  logic [NV-1:0]     voice_active;
  logic              overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  voice_scheduler #(
    .NUM_KEYS(NK), .NUM_VOICES(NV), .PHASE_W(PW), .LUT_AW(AW), .LUT_W(LW)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .key_level(key_level),
    .key_incr(key_incr),
    .audio_out_allowed(allowed),
    .lut_addr(lut_addr),
    .lut_data(lut_data),
    .sample_out(sample_out),
    .write_audio_out(write_audio_out),
    .voice_active(voice_active),
    .overflow(overflow)
  );

  // Identity LUT: one-cycle synchronous read, address sign-extended.
  always @(posedge clk) lut_data <= {{(LW-AW){lut_addr[AW-1]}}, lut_addr};

  // ---------------------------------------------------------------------------
  // Reference model. Transaction level: a whole sample is computed when a
  // sequence starts; m_busy counts the cycles left until the strobe.
  // ---------------------------------------------------------------------------
  bit          m_held [NK];
  int          m_scan;
  bit          m_act  [NV];
  int          m_key  [NV];
  logic [31:0] m_ph   [NV];
  int          m_age  [NV];
  bit          m_ovf;
  int          m_busy;
  logic [AW-1:0] m_addr [NV];
  logic [31:0] m_pend;
  logic [31:0] m_sample;
  int          m_sum, m_free, m_tgt;
  logic        exp_w;

  function automatic logic [NV-1:0] m_vec();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_act[i];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < NK; k++) m_held[k] = 0;
        for (int v = 0; v < NV; v++) begin
          m_act[v] = 0; m_key[v] = 0; m_ph[v] = '0; m_age[v] = 0; m_addr[v] = '0;
        end
        m_scan = 0; m_ovf = 0; m_busy = 0; m_pend = '0; m_sample = '0;
      end else if (m_busy == 0) begin
        if (key_level[m_scan] && !m_held[m_scan]) begin
          m_held[m_scan] = 1;
          m_free = -1;
          for (int v = 0; v < NV; v++) if (!m_act[v] && m_free < 0) m_free = v;
          m_tgt = m_free;
          if (m_free < 0) begin
            m_ovf = 1;
`ifdef VOICE_STEAL_EN
            m_tgt = 0;
            for (int v = 1; v < NV; v++) if (m_age[v] > m_age[m_tgt]) m_tgt = v;
`endif
          end
          if (m_tgt >= 0) begin
            for (int v = 0; v < NV; v++)
              if (m_act[v] && v != m_tgt && m_age[v] < NV - 1) m_age[v]++;
            m_act[m_tgt] = 1; m_key[m_tgt] = m_scan; m_ph[m_tgt] = '0; m_age[m_tgt] = 0;
          end
        end else if (!key_level[m_scan] && m_held[m_scan]) begin
          m_held[m_scan] = 0;
          for (int v = 0; v < NV; v++)
            if (m_act[v] && m_key[v] == m_scan) begin m_act[v] = 0; m_ph[v] = '0; end
        end
        m_scan = (m_scan + 1) % NK;
        if (allowed) begin
          m_sum = 0;
          for (int v = 0; v < NV; v++) begin
            m_addr[v] = m_ph[v][PW-1 -: AW];
            if (m_act[v]) begin
              m_sum += int'($signed(m_ph[v][PW-1 -: AW]));
              m_ph[v] = m_ph[v] + key_incr[m_key[v]*PW +: PW];
            end
          end
          m_pend = 32'(m_sum * 16384);
          m_busy = NV + 2;
        end
      end else begin
        m_busy--;
        if (m_busy == 1) m_sample = m_pend;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; allowed = 1'b0; key_level = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_incr();
    for (int k = 0; k < NK; k++) key_incr[k*PW +: PW] = $urandom();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    vectors++; if (sample_out !== 32'h0) begin miscompares++; $display("FAIL reset_sample got=%h want=0", sample_out); end
    vectors++; if (voice_active !== 4'b0000) begin miscompares++; $display("FAIL reset_active got=%b want=0000", voice_active); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    vectors++; if (write_audio_out !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got=%b want=0", write_audio_out); end
    vectors++; if (lut_addr !== '0) begin miscompares++; $display("FAIL reset_lut_addr got=%h want=0", lut_addr); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      vectors++;
      if (write_audio_out !== 1'b0 || voice_active !== 4'b0000) begin
        miscompares++; $display("FAIL idle_quiet cyc=%0d strobe=%b active=%b want 0/0000", c, write_audio_out, voice_active);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_key();
    int nstrobe, last, cyc;
    do_reset();
    rand_incr();
    key_incr[5*PW +: PW] = 32'h0040_0000;
    key_level = 10'b00_0010_0000;
    repeat (NK + 1) @(negedge clk);
    vectors++; if (voice_active !== 4'b0001) begin miscompares++; $display("FAIL single_active got=%b want=0001", voice_active); end
    allowed = 1'b1;
    nstrobe = 0; last = -1; cyc = 0;
    while (nstrobe < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      exp_w = (m_busy == 1);
      vectors++;
      if (write_audio_out !== exp_w) begin miscompares++; $display("FAIL single_strobe cyc=%0d got=%b want=%b", cyc, write_audio_out, exp_w); end
      if (m_busy >= 3) begin
        vectors++;
        if (lut_addr !== m_addr[NV+2-m_busy]) begin miscompares++; $display("FAIL single_lut_addr cyc=%0d got=%h want=%h", cyc, lut_addr, m_addr[NV+2-m_busy]); end
      end
      if (write_audio_out) begin
        vectors++;
        if (sample_out !== 32'(nstrobe * 32'h4000)) begin
          miscompares++; $display("FAIL single_sample n=%0d got=%h want=%h", nstrobe, sample_out, 32'(nstrobe * 32'h4000));
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 7) begin miscompares++; $display("FAIL single_spacing got=%0d want=7", cyc - last); end
        end
        last = cyc; nstrobe++;
      end
    end
    if (nstrobe < 4) begin vectors++; miscompares++; $display("FAIL single_timeout strobes got=%0d want=4", nstrobe); end
    allowed = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_release();
    do_reset();
    rand_incr();
    key_level = 10'b00_0000_0111;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      exp_w = (m_busy == 1);
      vectors++;
      if (write_audio_out !== exp_w) begin miscompares++; $display("FAIL rel_strobe cyc=%0d got=%b want=%b", c, write_audio_out, exp_w); end
      vectors++;
      if (voice_active !== m_vec()) begin miscompares++; $display("FAIL rel_active_model cyc=%0d got=%b want=%b", c, voice_active, m_vec()); end
      if (m_busy >= 3) begin
        vectors++;
        if (lut_addr !== m_addr[NV+2-m_busy]) begin miscompares++; $display("FAIL rel_lut_addr cyc=%0d got=%h want=%h", c, lut_addr, m_addr[NV+2-m_busy]); end
      end
      if (exp_w) begin
        vectors++;
        if (sample_out !== m_sample) begin miscompares++; $display("FAIL rel_sample cyc=%0d got=%h want=%h", c, sample_out, m_sample); end
      end
      if (c == NK + 1) begin
        vectors++;
        if (voice_active !== 4'b0111) begin miscompares++; $display("FAIL rel_three got=%b want=0111", voice_active); end
        allowed = 1'b1;
      end
      if (c == 50) allowed = 1'b0;
      if (c == 60) key_level[1] = 1'b0;
      if (c == 78) begin
        vectors++;
        if (voice_active !== 4'b0101) begin miscompares++; $display("FAIL rel_after got=%b want=0101", voice_active); end
        allowed = 1'b1;
      end
    end
    allowed = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    int nstrobe, lo, sum;
    logic [31:0] exp2;
    do_reset();
    rand_incr();
`ifdef VOICE_STEAL_EN
    lo = 1;   // voice 0 was stolen by key 4; key 0 is silent
`else
    lo = 0;   // key 4 was dropped
`endif
    sum = 0;
    for (int k = lo; k < lo + 4; k++) sum += int'($signed(key_incr[k*PW + PW - 1 -: AW]));
    exp2 = 32'(sum * 16384);
    key_level = 10'b00_0001_1111;
    nstrobe = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      exp_w = (m_busy == 1);
      vectors++;
      if (write_audio_out !== exp_w) begin miscompares++; $display("FAIL ovf_strobe cyc=%0d got=%b want=%b", c, write_audio_out, exp_w); end
      vectors++;
      if (overflow !== m_ovf) begin miscompares++; $display("FAIL ovf_flag_model cyc=%0d got=%b want=%b", c, overflow, m_ovf); end
      if (m_busy >= 3) begin
        vectors++;
        if (lut_addr !== m_addr[NV+2-m_busy]) begin miscompares++; $display("FAIL ovf_lut_addr cyc=%0d got=%h want=%h", c, lut_addr, m_addr[NV+2-m_busy]); end
      end
      if (write_audio_out) begin
        nstrobe++;
        vectors++;
        if (sample_out !== m_sample) begin miscompares++; $display("FAIL ovf_sample cyc=%0d got=%h want=%h", c, sample_out, m_sample); end
        if (nstrobe == 2) begin
          vectors++;
          if (sample_out !== exp2) begin miscompares++; $display("FAIL ovf_voice_keys got=%h want=%h", sample_out, exp2); end
        end
      end
      if (c == 20) begin
        vectors++;
        if (voice_active !== 4'b1111) begin miscompares++; $display("FAIL ovf_active got=%b want=1111", voice_active); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b want=1", overflow); end
        allowed = 1'b1;
      end
    end
    if (nstrobe < 2) begin vectors++; miscompares++; $display("FAIL ovf_timeout strobes got=%0d want>=2", nstrobe); end
    allowed = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int idx;
    do_reset();
    rand_incr();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      exp_w = (m_busy == 1);
      vectors++;
      if (write_audio_out !== exp_w) begin miscompares++; $display("FAIL rnd_strobe cyc=%0d got=%b want=%b", c, write_audio_out, exp_w); end
      vectors++;
      if (voice_active !== m_vec()) begin miscompares++; $display("FAIL rnd_active cyc=%0d got=%b want=%b", c, voice_active, m_vec()); end
      vectors++;
      if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow cyc=%0d got=%b want=%b", c, overflow, m_ovf); end
      if (m_busy >= 3) begin
        vectors++;
        if (lut_addr !== m_addr[NV+2-m_busy]) begin miscompares++; $display("FAIL rnd_lut_addr cyc=%0d got=%h want=%h", c, lut_addr, m_addr[NV+2-m_busy]); end
      end
      if (exp_w) begin
        vectors++;
        if (sample_out !== m_sample) begin miscompares++; $display("FAIL rnd_sample cyc=%0d got=%h want=%h", c, sample_out, m_sample); end
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NK - 1);
        key_level[idx] = ~key_level[idx];
      end
      allowed = ($urandom_range(0, 3) != 0);
    end
    allowed = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int nstrobe, rc, post;
    bit did;
    do_reset();
    rand_incr();
    key_level = 10'b00_1000_0100;
    repeat (NK + 1) @(negedge clk);
    allowed = 1'b1;
    nstrobe = 0; did = 0; rc = 0; post = 0;
    for (int c = 0; c < 200 && post < 2; c++) begin
      @(negedge clk);
      exp_w = (m_busy == 1);
      vectors++;
      if (write_audio_out !== exp_w) begin miscompares++; $display("FAIL rst_strobe cyc=%0d got=%b want=%b", c, write_audio_out, exp_w); end
      if (m_busy >= 3) begin
        vectors++;
        if (lut_addr !== m_addr[NV+2-m_busy]) begin miscompares++; $display("FAIL rst_lut_addr cyc=%0d got=%h want=%h", c, lut_addr, m_addr[NV+2-m_busy]); end
      end
      if (write_audio_out) begin
        vectors++;
        if (sample_out !== m_sample) begin miscompares++; $display("FAIL rst_sample cyc=%0d got=%h want=%h", c, sample_out, m_sample); end
        if (did) begin
          if (post == 0) begin
            vectors++;
            if (sample_out !== 32'h0) begin miscompares++; $display("FAIL rst_first_after got=%h want=0", sample_out); end
          end
          post++;
        end else begin
          nstrobe++;
        end
      end
      if (did && c < rc + 3) begin
        vectors++;
        if (write_audio_out !== 1'b0 || voice_active !== 4'b0000 || sample_out !== 32'h0) begin
          miscompares++; $display("FAIL rst_hold cyc=%0d strobe=%b active=%b sample=%h want 0", c, write_audio_out, voice_active, sample_out);
        end
      end
      if (did && c == rc + 3) reset_n = 1'b1;
      if (!did && nstrobe >= 2 && m_busy == NV) begin
        reset_n = 1'b0; did = 1; rc = c;
      end
    end
    if (post < 2) begin vectors++; miscompares++; $display("FAIL rst_timeout strobes_after got=%0d want=2", post); end
    reset_n = 1'b1;
    allowed = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b1;
    allowed   = 1'b0;
    key_level = '0;
    key_incr  = '0;
    test_reset();
    test_single_key();
    test_release();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
